// File: rtl/rand_byte_collector.sv
// -----------------------------------------------------------------------------
// rand_byte_collector
//
// Consumer end of the entropy unit. It samples the raw random bit stream while
// the enable-chain flag is high and runs a repetition-count health test on
// every raw sample. Accepted bits are packed MSB-first into WIDTH-bit words,
// and each word is offered on a valid/ready handshake.
//
// Parameters
//   WIDTH      output word width in bits (2..32)
//   REP_LIMIT  identical consecutive raw bits that declare a failure (2..255)
//
// Ports
//   i_clk         clock, all logic on the rising edge
//   i_res_n       asynchronous active-low reset
//   i_random      raw random bit, already synchronised to i_clk
//   i_enChain     source valid: i_random is sampled only when high
//   i_ready       consumer ready; a word transfers on o_valid && i_ready
//   i_clear_fail  clears a sticky health failure (level-sampled)
//   o_data        packed word; the first accepted bit lands in the MSB
//   o_valid       o_data holds a word that has not been transferred yet
//   o_drop        one-cycle pulse: a completed word was discarded
//   o_fail        sticky health failure
//
// Optional feature
//   RAND_COLLECT_VN_EN  when defined, von Neumann debiasing sits between
//                       sampling and packing (10 -> 1, 01 -> 0, 00/11 -> none).
//                       The health test still sees every raw sample.
// -----------------------------------------------------------------------------
module rand_byte_collector #(
  parameter int WIDTH     = 8,
  parameter int REP_LIMIT = 16
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic             i_random,
  input  logic             i_enChain,
  input  logic             i_ready,
  input  logic             i_clear_fail,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_drop,
  output logic             o_fail
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int REP_W = $clog2(REP_LIMIT);

  typedef enum logic {
    COLLECT = 1'b0,
    FAIL    = 1'b1
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  sr;
  logic [CNT_W-1:0]  cnt;
  logic [REP_W-1:0]  rep;
  logic              last_bit;
  // Marks that last_bit holds a real sample; the first sample after reset
  // is treated as a change of value.
  logic              have_last;

  logic              sample;
  logic              same_bit;
  logic              fail_now;
  logic [REP_W-1:0]  rep_nxt;
  logic              accept;
  logic              acc_bit;
  logic              word_done;
  logic [WIDTH-1:0]  sr_nxt;

  assign sample = (state == COLLECT) && i_enChain;

  // Repetition counter: rep counts repeats beyond the first bit of a run, so
  // a run of REP_LIMIT identical bits is the one that would push rep to
  // REP_LIMIT-1.
  always_comb begin
    same_bit = have_last && (i_random == last_bit);
    rep_nxt  = rep;
    fail_now = 1'b0;
    if (same_bit) begin
      if (rep < REP_W'(REP_LIMIT - 1)) begin
        rep_nxt = rep + REP_W'(1);
      end
      if (rep == REP_W'(REP_LIMIT - 2)) begin
        fail_now = sample;
      end
    end else begin
      rep_nxt = '0;
    end
  end

`ifdef RAND_COLLECT_VN_EN
  logic pair_flag;
  logic pair_bit;

  // A pair yields a bit only when its halves differ; the result equals the
  // first half (10 -> 1, 01 -> 0).
  assign accept  = sample && pair_flag && (pair_bit != i_random);
  assign acc_bit = pair_bit;

  // Pairing restarts whenever the source drops its enable, on a failure, and
  // while the block sits in FAIL.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      pair_flag <= 1'b0;
      pair_bit  <= 1'b0;
    end else if (!sample || fail_now) begin
      pair_flag <= 1'b0;
    end else begin
      pair_flag <= !pair_flag;
      if (!pair_flag) begin
        pair_bit <= i_random;
      end
    end
  end
`else
  assign accept  = sample;
  assign acc_bit = i_random;
`endif

  assign sr_nxt    = {sr[WIDTH-2:0], acc_bit};
  assign word_done = accept && (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state     <= COLLECT;
      sr        <= '0;
      cnt       <= '0;
      rep       <= '0;
      last_bit  <= 1'b0;
      have_last <= 1'b0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_drop    <= 1'b0;
      o_fail    <= 1'b0;
    end else begin
      o_drop <= 1'b0;
      case (state)
        COLLECT: begin
          if (sample) begin
            last_bit  <= i_random;
            have_last <= 1'b1;
            rep       <= rep_nxt;
          end
          if (fail_now) begin
            // A word completing on the failing sample is lost, not dropped.
            state   <= FAIL;
            o_fail  <= 1'b1;
            o_valid <= 1'b0;
            sr      <= '0;
            cnt     <= '0;
          end else begin
            if (o_valid && i_ready) begin
              o_valid <= 1'b0;
            end
            if (accept) begin
              sr <= sr_nxt;
              if (word_done) begin
                cnt <= '0;
                if (o_valid && !i_ready) begin
                  // Held word stays untouched; the new one is discarded.
                  o_drop <= 1'b1;
                end else begin
                  o_data  <= sr_nxt;
                  o_valid <= 1'b1;
                end
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
        end
        FAIL: begin
          o_valid <= 1'b0;
          if (i_clear_fail) begin
            state  <= COLLECT;
            o_fail <= 1'b0;
            rep    <= '0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_byte_collector.sv
module tb_rand_byte_collector;

  logic       i_clk = 1'b0;
  logic       i_res_n;
  logic       i_random;
  logic       i_enChain;
  logic       i_ready;
  logic       i_clear_fail;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_drop;
  logic       o_fail;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] raw;   // raw bits, sent from bit n-1 down to bit 0
    int          n;
    logic [7:0]  exp;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb_q[$];

  rand_byte_collector #(.WIDTH(8), .REP_LIMIT(16)) dut (
    .i_clk       (i_clk),
    .i_res_n     (i_res_n),
    .i_random    (i_random),
    .i_enChain   (i_enChain),
    .i_ready     (i_ready),
    .i_clear_fail(i_clear_fail),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_drop      (o_drop),
    .o_fail      (o_fail)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: a transfer takes place at the next rising edge, so it is
  // observed on the falling edge while o_valid && i_ready hold.
  always @(negedge i_clk) begin
    if (i_res_n && o_valid && i_ready) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected actual=%0h required=none", o_data);
      end else begin
        logic [7:0] e;
        e = sb_q.pop_front();
        if (o_data !== e) begin
          failures++;
          $display("FAIL sb_word actual=%0h required=%0h", o_data, e);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    i_random  = b;
    i_enChain = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_enChain = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  initial begin
    i_res_n      = 1'b0;
    i_random     = 1'b0;
    i_enChain    = 1'b0;
    i_ready      = 1'b1;
    i_clear_fail = 1'b0;

`ifdef RAND_COLLECT_VN_EN
    // 10,01,11,00,10,10,01,01,10,01 -> 1,0,-,-,1,1,0,0,1,0 = 8'hB2
    vecs.push_back('{32'b10_01_11_00_10_10_01_01_10_01, 20, 8'hB2});
    // 10,01,11,00,10,01,01,10,01,10 -> 1,0,-,-,1,0,0,1,0,1 = 8'hA5
    vecs.push_back('{32'b10_01_11_00_10_01_01_10_01_10, 20, 8'hA5});
`else
    vecs.push_back('{32'b10110010, 8, 8'hB2});
    vecs.push_back('{32'b01010101, 8, 8'h55});
    vecs.push_back('{32'b11001010, 8, 8'hCA});
    vecs.push_back('{32'b00111100, 8, 8'h3C});
    vecs.push_back('{32'b10011001, 8, 8'h99});
`endif

    #1;
    chk("rst_data",  o_data,  0);
    chk("rst_valid", o_valid, 0);
    chk("rst_drop",  o_drop,  0);
    chk("rst_fail",  o_fail,  0);
    @(posedge i_clk);
    #1;
    i_res_n = 1'b1;
    idle();

`ifdef RAND_COLLECT_VN_EN
    // A lone first half followed by a disabled cycle must not pair up.
    send_bit(1'b1);
    idle();
`endif

    // Table: each word valid one cycle after its last bit, then gone.
    for (int v = 0; v < vecs.size(); v++) begin
      sb_q.push_back(vecs[v].exp);
      for (int i = vecs[v].n - 1; i >= 0; i--) send_bit(vecs[v].raw[i]);
      chk($sformatf("vec%0d_valid", v), o_valid, 1);
      chk($sformatf("vec%0d_data", v),  o_data,  vecs[v].exp);
      idle();
      chk($sformatf("vec%0d_valid_clr", v), o_valid, 0);
    end

`ifdef RAND_COLLECT_VN_EN
    // Health test sees raw bits even though 11 pairs yield nothing.
    send_ones(15);
    chk("vn_nofail15", o_fail, 0);
    send_bit(1'b1);
    chk("vn_fail16", o_fail, 1);
    i_clear_fail = 1'b1;
    idle();
    i_clear_fail = 1'b0;
    chk("vn_clear", o_fail, 0);
`else
    // T2: hold, overflow drop, data stable.
    i_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    chk("t2_valid", o_valid, 1);
    chk("t2_data",  o_data,  8'hAA);
    for (int i = 0; i < 7; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    chk("t2_nodrop15", o_drop, 0);
    send_bit(1'b0);
    chk("t2_drop",      o_drop,  1);
    chk("t2_data_hold", o_data,  8'hAA);
    chk("t2_valid_hold", o_valid, 1);
    idle();
    chk("t2_drop_pulse", o_drop, 0);
    sb_q.push_back(8'hAA);
    i_ready = 1'b1;
    idle();
    chk("t2_valid_clr", o_valid, 0);

    // T3a: 15 ones then a zero does not fail.
    sb_q.push_back(8'hFF);
    sb_q.push_back(8'hFE);
    send_ones(15);
    send_bit(1'b0);
    chk("t3_nofail", o_fail, 0);
    idle();
    // T3b: 16 ones fail; the word completing on bit 16 is lost silently.
    sb_q.push_back(8'hFF);
    send_ones(15);
    chk("t3_nofail15", o_fail, 0);
    send_bit(1'b1);
    chk("t3_fail",   o_fail,  1);
    chk("t3_valid0", o_valid, 0);
    chk("t3_drop0",  o_drop,  0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t3_sticky",   o_fail,  1);
    chk("t3_no_valid", o_valid, 0);

    // T4: clear, then 0,1 x4 -> 8'h55.
    i_clear_fail = 1'b1;
    idle();
    i_clear_fail = 1'b0;
    chk("t4_clear", o_fail, 0);
    sb_q.push_back(8'h55);
    for (int i = 0; i < 8; i++) send_bit(i[0]);
    chk("t4_valid", o_valid, 1);
    chk("t4_data",  o_data,  8'h55);
    idle();

    // T6: reset with a held word and a 5-bit partial word.
    i_ready = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'h69;
      send_bit(w[i]);
    end
    chk("t6_held", o_valid, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    i_enChain = 1'b0;
    #2;
    i_res_n = 1'b0;
    #1;
    chk("t6_async_valid", o_valid, 0);
    chk("t6_async_data",  o_data,  0);
    #1;
    i_res_n = 1'b1;
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    sb_q.push_back(8'hB2);
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] w;
      w = 8'hB2;
      send_bit(w[i]);
    end
    chk("t6_valid", o_valid, 1);
    chk("t6_data",  o_data,  8'hB2);
    idle();
`endif

    idle();
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
